// File: rtl/vol_ctrl.sv
// vol_ctrl: debounced up/down volume buttons with auto-repeat, producing a
// saturating attenuation level for the LED bar and a {att, att} decoder
// volume word delivered to the SCI writer over a req/ack handshake.
// Optional mute button is compiled in when VOL_CTRL_MUTE_EN is defined.
module vol_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int MAX_LEVEL       = 8,
  parameter int RESET_LEVEL     = 4,
  parameter int ATTEN_STEP      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
`ifdef VOL_CTRL_MUTE_EN
  input  logic        btn_mute,
`endif
  input  logic        upd_ack,
  output logic [4:0]  vol_level,
  output logic [15:0] vol_word,
  output logic        upd_req
);

`ifdef VOL_CTRL_MUTE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Decoder attenuation for a level; 8'hFF is reserved so the product clamps at 8'hFE.
  function automatic logic [7:0] att(input logic [4:0] lvl);
    int prod;
    prod = int'(lvl) * ATTEN_STEP;
    if (prod > 254) begin
      att = 8'hFE;
    end else begin
      att = prod[7:0];
    end
  endfunction

  logic [NB-1:0] raw_s;
  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [NB-1:0] deb_r;
  logic [NB-1:0] deb_d_r;
  logic [DW-1:0] deb_cnt_r [NB];
  logic [RW-1:0] rpt_cnt_r [2];
  logic [NB-1:0] press_s;
  logic [1:0]    rpt_fire_s;
  logic          both_s;
  logic          up_evt_s;
  logic          dn_evt_s;
  logic [4:0]    level_r;
  logic [4:0]    level_nxt_s;
  logic [4:0]    lvl_out_nxt_s;
  logic [15:0]   word_nxt_s;
  logic          change_s;
  logic          pending_r;
  state_t        state_r;
`ifdef VOL_CTRL_MUTE_EN
  logic          mute_r;
  logic          mute_nxt_s;
  assign raw_s = {btn_mute, btn_down, btn_up};
`else
  assign raw_s = {btn_down, btn_up};
`endif

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {NB{1'b0}};
      sync2_r <= {NB{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: flip the stable state only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r   <= {NB{1'b0}};
      deb_d_r <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        deb_cnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      deb_d_r <= deb_r;
      for (int i = 0; i < NB; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= {DW{1'b0}};
        end else if (deb_cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= {DW{1'b0}};
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Both volume buttons held together blocks every event, including mute.
  assign both_s = deb_r[0] & deb_r[1];

  // Press and auto-repeat event pulses.
  always_comb begin
    press_s    = deb_r & ~deb_d_r & {NB{~both_s}};
    rpt_fire_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      rpt_fire_s[i] = deb_r[i] & ~both_s & (rpt_cnt_r[i] == RW'(REPEAT_DELAY));
    end
    up_evt_s = press_s[0] | rpt_fire_s[0];
    dn_evt_s = press_s[1] | rpt_fire_s[1];
  end

  // Repeat counters: count cycles since the press; after a fire, rewind so the next lands REPEAT_PERIOD later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_r[0] <= {RW{1'b0}};
      rpt_cnt_r[1] <= {RW{1'b0}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!deb_r[i] || both_s) begin
          rpt_cnt_r[i] <= {RW{1'b0}};
        end else if (rpt_fire_s[i]) begin
          rpt_cnt_r[i] <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
        end else begin
          rpt_cnt_r[i] <= rpt_cnt_r[i] + RW'(1);
        end
      end
    end
  end

  // Next stored level, mute state, displayed level and decoder word.
  always_comb begin
    level_nxt_s = level_r;
    if (up_evt_s) begin
      if (level_r != 5'd0) begin
        level_nxt_s = level_r - 5'd1;
      end else begin
        level_nxt_s = level_r;
      end
    end else if (dn_evt_s) begin
      if (level_r != 5'(MAX_LEVEL)) begin
        level_nxt_s = level_r + 5'd1;
      end else begin
        level_nxt_s = level_r;
      end
    end else begin
      level_nxt_s = level_r;
    end
`ifdef VOL_CTRL_MUTE_EN
    mute_nxt_s = mute_r;
    if (up_evt_s || dn_evt_s) begin
      mute_nxt_s = 1'b0;
    end else if (press_s[2]) begin
      mute_nxt_s = ~mute_r;
    end else begin
      mute_nxt_s = mute_r;
    end
    change_s = (level_nxt_s != level_r) || (mute_nxt_s != mute_r);
    if (mute_nxt_s) begin
      word_nxt_s    = 16'hFEFE;
      lvl_out_nxt_s = 5'(MAX_LEVEL);
    end else begin
      word_nxt_s    = {att(level_nxt_s), att(level_nxt_s)};
      lvl_out_nxt_s = level_nxt_s;
    end
`else
    change_s      = (level_nxt_s != level_r);
    word_nxt_s    = {att(level_nxt_s), att(level_nxt_s)};
    lvl_out_nxt_s = level_nxt_s;
`endif
  end

  // Level registers and the SCI handshake FSM; changes during REQ coalesce into pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r   <= 5'(RESET_LEVEL);
      vol_level <= 5'(RESET_LEVEL);
      vol_word  <= {att(5'(RESET_LEVEL)), att(5'(RESET_LEVEL))};
      upd_req   <= 1'b0;
      pending_r <= 1'b0;
      state_r   <= ST_INIT;
`ifdef VOL_CTRL_MUTE_EN
      mute_r    <= 1'b0;
`endif
    end else begin
      level_r   <= level_nxt_s;
      vol_level <= lvl_out_nxt_s;
`ifdef VOL_CTRL_MUTE_EN
      mute_r    <= mute_nxt_s;
`endif
      case (state_r)
        ST_INIT: begin
          vol_word  <= word_nxt_s;
          upd_req   <= 1'b1;
          pending_r <= 1'b0;
          state_r   <= ST_REQ;
        end
        ST_IDLE: begin
          if (change_s) begin
            vol_word <= word_nxt_s;
            upd_req  <= 1'b1;
            state_r  <= ST_REQ;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (change_s) begin
            pending_r <= 1'b1;
          end else begin
            pending_r <= pending_r;
          end
          if (upd_ack) begin
            upd_req <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_DONE: begin
          if (pending_r || change_s) begin
            vol_word  <= word_nxt_s;
            pending_r <= 1'b0;
            upd_req   <= 1'b1;
            state_r   <= ST_REQ;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          upd_req   <= 1'b0;
          pending_r <= 1'b0;
          state_r   <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vol_ctrl.sv
// Directed testbench for vol_ctrl with short debounce/repeat timing.
// Define VOL_CTRL_MUTE_EN to also exercise the mute button.
module tb_vol_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up;
  logic        btn_down;
`ifdef VOL_CTRL_MUTE_EN
  logic        btn_mute;
`endif
  logic        upd_ack;
  logic [4:0]  vol_level;
  logic [15:0] vol_word;
  logic        upd_req;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic req_prev = 1'b0;
  logic auto_ack = 1'b1;

  vol_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
`ifdef VOL_CTRL_MUTE_EN
    .btn_mute (btn_mute),
`endif
    .upd_ack  (upd_ack),
    .vol_level(vol_level),
    .vol_word (vol_word),
    .upd_req  (upd_req)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles; sample 1 unit after each rising edge, count request
  // rising edges, and optionally acknowledge one cycle after upd_req is seen.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (upd_req && !req_prev) rises++;
      req_prev = upd_req;
      if (auto_ack) upd_ack = upd_req;
    end
  endtask

  // Reset, release, and let the INIT write complete with auto-acknowledge.
  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n    = 1'b1;
    auto_ack = 1'b1;
    req_prev = 1'b0;
    tick(6);
    rises = 0;
  endtask

  // Hold the given buttons 10 cycles, then release and let debounce settle.
  task automatic press(input logic u, input logic d);
    btn_up   = u;
    btn_down = d;
    tick(10);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(20);
  endtask

  initial begin
    rst_n    = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
`ifdef VOL_CTRL_MUTE_EN
    btn_mute = 1'b0;
`endif
    upd_ack  = 1'b0;

    // Reset state and INIT write.
    tick(2);
    chk("rst_level", 32'(vol_level), 32'd4);
    chk("rst_word",  32'(vol_word),  32'h4040);
    chk("rst_req",   32'(upd_req),   32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("init_req",  32'(upd_req),   32'd1);
    chk("init_word", 32'(vol_word),  32'h4040);
    tick(1);
    chk("init_ack_drop", 32'(upd_req), 32'd0);
    tick(5);
    rises = 0;

    // Two-cycle glitch is filtered.
    btn_up = 1'b1;
    tick(2);
    btn_up = 1'b0;
    tick(20);
    chk("glitch_level", 32'(vol_level), 32'd4);
    chk("glitch_rises", 32'(rises),     32'd0);

    // Clean up press: event after debounce, level applied one cycle later.
    btn_up = 1'b1;
    tick(6);
    chk("up_before", 32'(vol_level), 32'd4);
    tick(1);
    chk("up_level", 32'(vol_level), 32'd3);
    chk("up_word",  32'(vol_word),  32'h3030);
    chk("up_req",   32'(upd_req),   32'd1);
    tick(3);
    btn_up = 1'b0;
    tick(20);
    chk("up_rises", 32'(rises),   32'd1);
    chk("up_idle",  32'(upd_req), 32'd0);

    // Held down button: press, repeat after 20, then every 8, saturating at 8.
    do_reset();
    btn_down = 1'b1;
    tick(7);
    chk("rpt_press", 32'(vol_level), 32'd5);
    tick(19);
    chk("rpt_wait",  32'(vol_level), 32'd5);
    tick(1);
    chk("rpt_first", 32'(vol_level), 32'd6);
    tick(7);
    chk("rpt_gap",   32'(vol_level), 32'd6);
    tick(1);
    chk("rpt_second", 32'(vol_level), 32'd7);
    tick(8);
    chk("rpt_third", 32'(vol_level), 32'd8);
    chk("rpt_word",  32'(vol_word),  32'h8080);
    tick(57);
    btn_down = 1'b0;
    tick(20);
    chk("sat_level", 32'(vol_level), 32'd8);
    chk("sat_word",  32'(vol_word),  32'h8080);
    chk("sat_rises", 32'(rises),     32'd4);

    // Changes during a stalled request coalesce into one follow-up write.
    do_reset();
    auto_ack = 1'b0;
    upd_ack  = 1'b0;
    press(1'b0, 1'b1);
    chk("stall_word1", 32'(vol_word),  32'h5050);
    chk("stall_req1",  32'(upd_req),   32'd1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("stall_level", 32'(vol_level), 32'd7);
    chk("stall_word",  32'(vol_word),  32'h5050);
    chk("stall_req",   32'(upd_req),   32'd1);
    chk("stall_rises", 32'(rises),     32'd1);
    upd_ack = 1'b1;
    tick(1);
    upd_ack = 1'b0;
    chk("done_req",  32'(upd_req),  32'd0);
    chk("done_word", 32'(vol_word), 32'h5050);
    tick(1);
    chk("pend_req",   32'(upd_req),  32'd1);
    chk("pend_word",  32'(vol_word), 32'h7070);
    upd_ack = 1'b1;
    tick(1);
    upd_ack = 1'b0;
    tick(10);
    chk("pend_once",  32'(rises),   32'd2);
    chk("pend_clear", 32'(upd_req), 32'd0);

    // Acknowledge outside REQ has no effect.
    upd_ack = 1'b1;
    tick(5);
    upd_ack = 1'b0;
    tick(2);
    chk("stray_ack_req",   32'(upd_req), 32'd0);
    chk("stray_ack_rises", 32'(rises),   32'd2);

    // Reset while a request is outstanding returns to reset values at once.
    press(1'b0, 1'b1);
    chk("mid_req", 32'(upd_req), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("async_level", 32'(vol_level), 32'd4);
    chk("async_word",  32'(vol_word),  32'h4040);
    chk("async_req",   32'(upd_req),   32'd0);
    tick(2);
    rst_n    = 1'b1;
    auto_ack = 1'b1;
    req_prev = 1'b0;
    rises    = 0;
    tick(1);
    chk("reinit_req",  32'(upd_req),  32'd1);
    chk("reinit_word", 32'(vol_word), 32'h4040);
    tick(5);
    chk("reinit_rises", 32'(rises), 32'd1);

    // Both buttons held together: nothing happens.
    rises = 0;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(30);
    chk("both_mid", 32'(vol_level), 32'd4);
    tick(20);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(20);
    chk("both_level", 32'(vol_level), 32'd4);
    chk("both_word",  32'(vol_word),  32'h4040);
    chk("both_rises", 32'(rises),     32'd0);

`ifdef VOL_CTRL_MUTE_EN
    // Mute from level 2, then an up press unmutes and steps the stored level.
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("mute_pre", 32'(vol_level), 32'd2);
    btn_mute = 1'b1;
    tick(7);
    chk("mute_level", 32'(vol_level), 32'd8);
    chk("mute_word",  32'(vol_word),  32'hFEFE);
    tick(3);
    btn_mute = 1'b0;
    tick(20);
    btn_up = 1'b1;
    tick(7);
    chk("unmute_level", 32'(vol_level), 32'd1);
    chk("unmute_word",  32'(vol_word),  32'h1010);
    tick(3);
    btn_up = 1'b0;
    tick(20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
